// File: rtl/register_file_pkg.sv
// Shared RV32I definitions: register-file geometry and ABI register names.
package rv32i_defs;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [REG_ADDR_W-1:0] {
        ZERO = 5'd0,  RA   = 5'd1,  SP  = 5'd2,  GP  = 5'd3,
        TP   = 5'd4,  T0   = 5'd5,  T1  = 5'd6,  T2  = 5'd7,
        S0   = 5'd8,  S1   = 5'd9,  A0  = 5'd10, A1  = 5'd11,
        A2   = 5'd12, A3   = 5'd13, A4  = 5'd14, A5  = 5'd15,
        A6   = 5'd16, A7   = 5'd17, S2  = 5'd18, S3  = 5'd19,
        S4   = 5'd20, S5   = 5'd21, S6  = 5'd22, S7  = 5'd23,
        S8   = 5'd24, S9   = 5'd25, S10 = 5'd26, S11 = 5'd27,
        T3   = 5'd28, T4   = 5'd29, T5  = 5'd30, T6  = 5'd31
    } abi_reg_e;

endpackage

// File: rtl/register_file_if.sv
// Write-back / operand-read bus between the core stages and the register file.
interface register_file_if
    import rv32i_defs::*;
#(
    parameter int N = 32
);
    // Protocol: wr_ena is sampled on the rising clk edge together with
    // wr_addr/wr_data; wr_addr/wr_data are don't-care while wr_ena=0.
    // Reads have no handshake: rd_dataK follows rd_addrK combinationally.
    logic                  wr_ena;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [N-1:0]          wr_data;
    logic [REG_ADDR_W-1:0] rd_addr0;
    logic [N-1:0]          rd_data0;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [N-1:0]          rd_data1;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );

endinterface

// File: rtl/register_file_decoder.sv
// 5-to-32 one-hot decoder producing per-register write enables.
module decoder_5_to_32
    import rv32i_defs::*;
(
    input  logic                  ena,
    input  logic [REG_ADDR_W-1:0] in,
    output logic [NUM_REGS-1:0]   out
);

    assign out = ena ? (NUM_REGS'(1) << in) : '0;

endmodule

// File: rtl/register_file_register.sv
// Single N-bit register with load enable and asynchronous active-low clear.
module register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (ena) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/register_file.sv
// 32 x N register file: one synchronous write port, two combinational read ports, x0 tied to zero.
module register_file
    import rv32i_defs::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    logic [NUM_REGS-1:0] w_ena;
    logic [N-1:0]        w_q [NUM_REGS];
    logic [N-1:0]        w_rd0;
    logic [N-1:0]        w_rd1;
    logic                w_unused;

    decoder_5_to_32 u_dec (
        .ena (bus.wr_ena),
        .in  (bus.wr_addr),
        .out (w_ena)
    );

    // x0 has no storage; its decoded enable is intentionally dropped.
    assign w_q[0]   = '0;
    assign w_unused = w_ena[0];

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        register #(.N(N)) u_reg (
            .clk (clk),
            .rst (rst),
            .ena (w_ena[gi]),
            .d   (bus.wr_data),
            .q   (w_q[gi])
        );
    end

    // No write bypass: a same-cycle write becomes visible only after the edge.
    always_comb begin
        w_rd0 = w_q[bus.rd_addr0];
        w_rd1 = w_q[bus.rd_addr1];
    end

    assign bus.rd_data0 = w_rd0;
    assign bus.rd_data1 = w_rd1;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed sequences, a vector table and random traffic against an array model.
module tb_register_file;
    import rv32i_defs::*;

    localparam int W = 32;

    logic clk;
    logic rst;

    register_file_if #(.N(W)) bus ();

    register_file #(.N(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model / scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] model [NUM_REGS];
    logic [W-1:0] exp_q [$];

    function automatic logic [W-1:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? '0 : model[a];
    endfunction

    function automatic void model_wr(input logic we, input logic [4:0] a, input logic [W-1:0] d);
        if (we && a != 5'd0) model[a] = d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_ena   = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr0 = ra0;
        bus.rd_addr1 = ra1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       we;
        logic [4:0] wa;
        logic [W-1:0] wd;
        logic [4:0] ra0;
        logic [4:0] ra1;
        logic [W-1:0] exp0;  // read values just after the edge
        logic [W-1:0] exp1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [4:0]   ra0, ra1, wa;
        logic         we;
        logic [W-1:0] wd, e0, e1;

        // Expected values assume x1..x31 hold their own index when the table runs.
        vecs[0] = '{"gate_1",     1'b0, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h0000_0007, 32'h0000_0007};
        vecs[1] = '{"gate_2",     1'b0, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h0000_0007, 32'h0000_0007};
        vecs[2] = '{"gate_3",     1'b0, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h0000_0007, 32'h0000_0007};
        vecs[3] = '{"wr_x31",     1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 32'hA5A5_A5A5, 32'h0000_001E};
        vecs[4] = '{"wr_x1_zero", 1'b1, 5'd1,  32'h0000_0000, 5'd1,  5'd31, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[5] = '{"hold_x31",   1'b0, 5'd31, 32'h0000_0000, 5'd31, 5'd0,  32'hA5A5_A5A5, 32'h0000_0000};
        vecs[6] = '{"x0_again",   1'b1, 5'd0,  32'h5555_5555, 5'd0,  5'd2,  32'h0000_0000, 32'h0000_0002};

        model_clear();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);

        // ---- reset: asserted asynchronously, reads show zero ----
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("reset_rd0", bus.rd_data0, '0);
        bus.rd_addr1 = A7;
        #1;
        check("reset_rd1", bus.rd_data1, '0);

        // Write presented on the edge where rst is still low must be dropped.
        drive(1'b1, GP, 32'h3333_3333, GP, GP);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.wr_ena = 1'b0;
        #1;
        check("write_during_reset_ignored", bus.rd_data0, '0);

        // ---- basic write x1..x31 then sweep both ports ----
        tick();
        for (int i = 1; i < NUM_REGS; i++) begin
            drive(1'b1, 5'(i), W'(i), 5'd0, 5'd0);
            tick();
            model_wr(1'b1, 5'(i), W'(i));
        end
        bus.wr_ena = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.rd_addr0 = 5'(i);
            bus.rd_addr1 = 5'(31 - i);
            #1;
            check($sformatf("sweep_rd0[%0d]", i), bus.rd_data0, (i == 0) ? '0 : W'(i));
            check($sformatf("sweep_rd1[%0d]", 31 - i), bus.rd_data1, (i == 31) ? '0 : W'(31 - i));
        end

        // ---- x0 immunity ----
        drive(1'b1, ZERO, 32'hFFFF_FFFF, ZERO, ZERO);
        tick();
        bus.wr_ena = 1'b0;
        #1;
        check("x0_immune", bus.rd_data0, '0);
        for (int i = 1; i < NUM_REGS; i++) begin
            bus.rd_addr1 = 5'(i);
            #1;
            check($sformatf("x0_others[%0d]", i), bus.rd_data1, W'(i));
        end

        // ---- table-driven vectors ----
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
            tick();
            model_wr(vecs[v].we, vecs[v].wa, vecs[v].wd);
            check({vecs[v].name, "_rd0"}, bus.rd_data0, vecs[v].exp0);
            check({vecs[v].name, "_rd1"}, bus.rd_data1, vecs[v].exp1);
        end

        // ---- read-during-write on the same address ----
        drive(1'b1, A0, 32'hCAFE_F00D, A0, A0);
        #1;
        check("rdw_before_rd0", bus.rd_data0, 32'h0000_000A);
        check("rdw_before_rd1", bus.rd_data1, 32'h0000_000A);
        tick();
        model_wr(1'b1, A0, 32'hCAFE_F00D);
        bus.wr_ena = 1'b0;
        check("rdw_after_rd0", bus.rd_data0, 32'hCAFE_F00D);
        check("rdw_after_rd1", bus.rd_data1, 32'hCAFE_F00D);

        // ---- reset mid-operation ----
        drive(1'b1, T0, 32'hDEAD_BEEF, T0, T1);
        tick();
        drive(1'b1, T1, 32'h6666_6666, T0, T1);
        #2;
        check("pre_reset_x5", bus.rd_data0, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        check("async_reset_x5", bus.rd_data0, '0);
        tick();
        rst = 1'b1;
        bus.wr_ena = 1'b0;
        model_clear();
        tick();
        check("post_reset_x5", bus.rd_data0, '0);
        check("pending_write_lost_x6", bus.rd_data1, '0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 1000; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(we, wa, wd, ra0, ra1);
            #1;
            exp_q.push_back(model_rd(ra0));
            exp_q.push_back(model_rd(ra1));
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            check("rand_pre_rd0", bus.rd_data0, e0);
            check("rand_pre_rd1", bus.rd_data1, e1);
            tick();
            model_wr(we, wa, wd);
            check("rand_post_rd0", bus.rd_data0, model_rd(ra0));
            check("rand_post_rd1", bus.rd_data1, model_rd(ra1));
        end

        // ---- final report ----
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
